cmb_eval_arbiter: RTL
=====================

Name: cmb_eval_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared cmb evaluation unit (16-in / 4-out combinational block, instantiated beside this controller).
- Accepts 16-bit input vectors over valid/ready handshakes and drives the shared unit.
- Waits a fixed settle time, then captures the 4-bit result and returns it tagged with the requester id.
- Lets two test/stimulus sources share one combinational instance without contention.

Parameters:
- SETTLE, 2, cycles cmb_in is held before capture; legal range 1..15; 0 is treated as 1.
- CNT_W, 8, width of each hit counter (optional feature only).

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a vector
- req0_data  in  16  requester 0 vector, bit0=a .. bit15=p
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has a vector
- req1_data  in  16  requester 1 vector
- req1_ready  out  1  requester 1 accepted this cycle
- cmb_in  out  16  registered drive to the shared cmb unit
- cmb_out  in  4  cmb result {t,s,r,q}
- resp_valid  out  1  result available
- resp_id  out  1  requester that owns resp_data
- resp_data  out  4  captured {t,s,r,q}
- resp_ready  in  1  consumer takes the response
- busy  out  1  state != IDLE
- hit_clr  in  1  clears hit counters (optional feature)
- hit_cnt  out  4*CNT_W  per-output hit counters, [CNT_W-1:0] = q

Behaviour:
- Reset (synchronous, active-high) sets:
  - state to IDLE
  - cmb_in, resp_valid, resp_id, resp_data, busy to 0
  - settle counter to 0
  - last_grant to 1, so requester 0 wins the first tie
  - hit counters to 0
- Reset mid-operation drops the in-flight request and any pending response; the requester must re-present.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - grant = the only valid requester, or if both are valid, the one != last_grant.
  - reqN_ready = (state==IDLE) & grantN; combinational; at most one ready per cycle.
  - On handshake: cmb_in <= reqN_data, resp_id <= N, last_grant <= N, settle counter <= SETTLE-1, go to DRIVE.
- DRIVE:
  - cmb_in is held stable.
  - Counter decrements each cycle.
  - When the counter is 0: resp_data <= cmb_out, resp_valid <= 1, go to RESP.
- RESP:
  - resp_valid, resp_id and resp_data are held stable until resp_ready.
  - On resp_valid & resp_ready: resp_valid <= 0, go to IDLE.
  - A new accept is possible on the cycle after IDLE is re-entered (no same-cycle turnaround).
- Latency: an accept at edge k gives resp_valid high after edge k+SETTLE. With SETTLE=2 and resp_ready held high, throughput is one result per SETTLE+2 cycles.
- cmb_in keeps its last vector after a transaction; it is not cleared.
- reqN_data is ignored when not accepted; valid dropping before ready is legal and has no effect.
- resp_ready asserted outside RESP is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: CMB_EVAL_HIT_COUNT_EN.
- When defined:
  - On each capture, counter i increments if captured bit i == 1; counters saturate at all-ones.
  - hit_clr zeroes all counters next cycle.
  - hit_clr coinciding with a capture: clear wins.
- When undefined: no counter logic, hit_cnt tied to 0, hit_clr ignored; ports stay present.

Test Plan:
- Reset, then req0 sends 16'h0FFF with resp_ready=1 -> req0_ready high in cycle 1, cmb_in=16'h0FFF after the accept edge, resp_valid after 2 more edges with resp_id=0 and resp_data=4'b0111.
- req1 sends 16'h0000 -> resp_id=1, resp_data=4'b1100.
- Both requesters valid continuously after reset (req0=16'h0FFF, req1=16'h0000) -> grants alternate 0,1,0,1; responses alternate 4'b0111 / 4'b1100; never two readys in one cycle.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_id and resp_data stable; no reqN_ready asserted; completion occurs on the cycle resp_ready rises.
- Assert reset during DRIVE -> next cycle resp_valid=0, busy=0, cmb_in=0; next request is granted to req0 on a tie.
- With CMB_EVAL_HIT_COUNT_EN and CNT_W=2:
  - 4 accepts of 16'h0FFF -> q counter saturates at 3, t counter = 0.
  - Then hit_clr -> all counters 0.

Source files
------------

// File: rtl/cmb_eval_arbiter.sv
// cmb_eval_arbiter: two-requester round-robin arbiter and sequencer for one
// shared 16-in / 4-out combinational evaluation unit. A granted vector is
// driven onto cmb_in, held for SETTLE cycles, then the 4-bit result is
// captured and returned tagged with the requester id.
//
// Optional feature macro: CMB_EVAL_HIT_COUNT_EN
//   Defined   -> per-output saturating hit counters on every capture.
//   Undefined -> hit_cnt is tied to zero and hit_clr is ignored.
module cmb_eval_arbiter #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [15:0]        req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [15:0]        req1_data,
  output logic               req1_ready,
  output logic [15:0]        cmb_in,
  input  logic [3:0]         cmb_out,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [3:0]         resp_data,
  input  logic               resp_ready,
  output logic               busy,
  input  logic               hit_clr,
  output logic [4*CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // A settle time of 0 behaves as 1; the counter is 4 bits so cap at 15.
  localparam int         SETTLE_EFF  = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF - 1);

  state_t      state_q, state_d;
  logic [15:0] cmb_in_q, cmb_in_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [3:0]  resp_data_q, resp_data_d;
  logic [3:0]  settle_q, settle_d;
  logic        last_grant_q, last_grant_d;

  logic        grant0;
  logic        grant1;
  logic        capture;

  // Round-robin grant: a lone requester wins; on a tie the one that was
  // not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;

  // Result is sampled once the settle counter has run out in DRIVE.
  assign capture = (state_q == DRIVE) && (settle_q == 4'd0);

  // Next-state and datapath updates for the IDLE/DRIVE/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    cmb_in_d     = cmb_in_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    settle_d     = settle_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          cmb_in_d     = req0_data;
          resp_id_d    = 1'b0;
          last_grant_d = 1'b0;
          settle_d     = SETTLE_LOAD;
          state_d      = DRIVE;
        end else if (req1_ready) begin
          cmb_in_d     = req1_data;
          resp_id_d    = 1'b1;
          last_grant_d = 1'b1;
          settle_d     = SETTLE_LOAD;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        if (capture) begin
          resp_data_d  = cmb_out;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmb_in_q     <= 16'h0000;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 4'h0;
      settle_q     <= 4'h0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmb_in_q     <= cmb_in_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      settle_q     <= settle_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cmb_in     = cmb_in_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

`ifdef CMB_EVAL_HIT_COUNT_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hit
      logic [CNT_W-1:0] hit_d;
      logic [CNT_W-1:0] hit_q;

      // Saturating count of captures with this output bit set; clear wins.
      always_comb begin
        hit_d = hit_q;
        if (hit_clr) begin
          hit_d = '0;
        end else if (capture && cmb_out[gi] && (hit_q != {CNT_W{1'b1}})) begin
          hit_d = hit_q + CNT_W'(1);
        end
      end

      // Hit counter register.
      always_ff @(posedge clk) begin
        if (reset) begin
          hit_q <= '0;
        end else begin
          hit_q <= hit_d;
        end
      end

      assign hit_cnt[gi*CNT_W +: CNT_W] = hit_q;
    end
  endgenerate
`else
  logic unused_hit_clr;
  assign unused_hit_clr = hit_clr;
  assign hit_cnt        = '0;
`endif

endmodule
